x_serializer: RTL and testbench

Upstream feeder for the two-bit automaton that consumes a single-bit input `x` per clock. Accepts parallel words over a valid/ready handshake and shifts them out one bit per enabled clock on `x`. Has a one-entry holding buffer so consecutive words stream without a gap. Also marks valid bits and word boundaries for the downstream stage and the bench.

---
 rtl/automate_pkg.sv | 23 ++
 rtl/x_hold_buf.sv | 45 ++++
 rtl/x_serializer.sv | 123 ++++++++++++
 tb/tb_x_serializer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/automate_pkg.sv
// rtl/automate_pkg.sv - shared types and limits for the x-automaton feeder
//
// Contents:
//   ser_state_t   serializer FSM state {IDLE, SHIFT}
//   SER_WIDTH_MIN smallest legal word width
//   SER_WIDTH_MAX largest legal word width
//   ser_width_ok  elaboration-time range check for a word width

package automate_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int SER_WIDTH_MIN = 2;
    localparam int SER_WIDTH_MAX = 32;

    function automatic bit ser_width_ok(input int width);
        return (width >= SER_WIDTH_MIN) && (width <= SER_WIDTH_MAX);
    endfunction

endpackage

// File: rtl/x_hold_buf.sv
// rtl/x_hold_buf.sv - one-entry valid/ready holding register for x_serializer
//
// Ports:
//   clk        clock, rising edge
//   res        asynchronous active-low reset
//   din        parallel word offered upstream
//   din_valid  din is presented
//   din_ready  buffer empty; word accepted on din_valid & din_ready
//   take       serializer moves the buffered word into its shift register
//   hold       buffered word
//   hold_full  hold contains a word not yet taken

module x_hold_buf
    import automate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             take,
    output logic [WIDTH-1:0] hold,
    output logic             hold_full
);

    // take is only ever raised while hold_full=1 and accept needs
    // hold_full=0, so the two branches never compete on one edge.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (take) begin
            hold_full <= 1'b0;
        end else if (din_valid && !hold_full) begin
            hold      <= din;
            hold_full <= 1'b1;
        end
    end

    // Straight from the flop: no path from din_valid or step to din_ready.
    assign din_ready = ~hold_full;

endmodule

// File: rtl/x_serializer.sv
// rtl/x_serializer.sv - parallel-to-serial feeder for the two-bit x automaton
//
// Parameters:
//   WIDTH      bits per word, 2..32
//   LSB_FIRST  0: MSB shifted out first, 1: LSB first
// Ports:
//   clk        clock, rising edge
//   res        asynchronous active-low reset
//   din        parallel word to serialize
//   din_valid  din is presented
//   din_ready  holding buffer empty
//   step       advance enable; current bit consumed on a stepped edge
//   x          serial bit, 0 when no bit is valid
//   x_valid    x carries a data bit
//   word_done  one-cycle pulse after the last bit of a word is consumed
//   busy       x_valid or holding buffer full

module x_serializer
    import automate_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             step,
    output logic             x,
    output logic             x_valid,
    output logic             word_done,
    output logic             busy
);

    if (!ser_width_ok(WIDTH)) begin : g_width_check
        $error("x_serializer: WIDTH must lie within SER_WIDTH_MIN..SER_WIDTH_MAX");
    end

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    ser_state_t       state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic             last_step;
    logic             take;

    // Last bit of the word in sr is being consumed on this edge.
    assign last_step = (state == SHIFT) && step && (cnt == '0);

    // The buffered word moves into sr either from IDLE or straight behind
    // the last bit of the current word, which keeps back-to-back words gapless.
    assign take = hold_full && ((state == IDLE) || last_step);

    x_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .res       (res),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .take      (take),
        .hold      (hold),
        .hold_full (hold_full)
    );

    // Move the next bit onto the output end, zero filling behind it.
    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
        if (LSB_FIRST != 0) begin
            return {1'b0, v[WIDTH-1:1]};
        end else begin
            return {v[WIDTH-2:0], 1'b0};
        end
    endfunction

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            case (state)
                IDLE: begin
                    // step has no meaning here: there is no bit to consume.
                    if (hold_full) begin
                        sr    <= hold;
                        cnt   <= CNT_LAST;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (step) begin
                        if (cnt != '0) begin
                            sr  <= shift_out(sr);
                            cnt <= cnt - CW'(1);
                        end else begin
                            word_done <= 1'b1;
                            if (hold_full) begin
                                sr  <= hold;
                                cnt <= CNT_LAST;
                            end else begin
                                sr    <= '0;
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign x_valid = (state == SHIFT);
    assign x       = x_valid & ((LSB_FIRST != 0) ? sr[0] : sr[WIDTH-1]);
    assign busy    = x_valid | hold_full;

endmodule

// File: tb/tb_x_serializer.sv
// tb/tb_x_serializer.sv - self-checking bench for x_serializer (MSB-first and LSB-first)

module tb_x_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         res = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         step = 1'b0;

    logic din_ready, x, x_valid, word_done, busy;
    logic din_ready_l, x_l, x_valid_l, word_done_l, busy_l;

    always #5 clk = ~clk;

    x_serializer #(.WIDTH(W), .LSB_FIRST(0)) dut (
        .clk(clk), .res(res), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .step(step), .x(x), .x_valid(x_valid), .word_done(word_done), .busy(busy)
    );

    x_serializer #(.WIDTH(W), .LSB_FIRST(1)) dut_l (
        .clk(clk), .res(res), .din(din), .din_valid(din_valid), .din_ready(din_ready_l),
        .step(step), .x(x_l), .x_valid(x_valid_l), .word_done(word_done_l), .busy(busy_l)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: the bits each DUT still owes, in the order they must appear.
    bit q0[$];
    bit q1[$];
    int consumed[2];

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic bit qpop(input int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void qpush(input int d, input bit b);
        if (d == 0) q0.push_back(b);
        else q1.push_back(b);
    endfunction

    function automatic void model_reset();
        q0.delete();
        q1.delete();
        consumed[0] = 0;
        consumed[1] = 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; afterwards every output of both DUTs is checked
    // against the bit-stream model.
    task automatic cyc();
        bit           acc  [2];
        bit           cons [2];
        logic         xpre [2];
        logic [W-1:0] w;
        acc[0]  = din_valid & din_ready;
        acc[1]  = din_valid & din_ready_l;
        cons[0] = step & x_valid;
        cons[1] = step & x_valid_l;
        xpre[0] = x;
        xpre[1] = x_l;
        w       = din;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            bit idle_hold;
            bit exv;
            int sz;
            if (cons[d]) begin
                chk($sformatf("bit_avail_d%0d", d), qsize(d) > 0, 1);
                if (qsize(d) > 0) chk($sformatf("bit_value_d%0d", d), xpre[d], qpop(d));
                consumed[d]++;
            end
            // A word accepted while nothing is in flight sits one cycle in hold.
            idle_hold = acc[d] && (qsize(d) == 0);
            if (acc[d]) begin
                for (int i = 0; i < W; i++) qpush(d, (d == 0) ? w[W-1-i] : w[i]);
            end
            sz  = qsize(d);
            exv = (sz > 0) && !idle_hold;
            chk($sformatf("x_valid_d%0d", d), (d == 0) ? x_valid : x_valid_l, exv);
            chk($sformatf("busy_d%0d", d), (d == 0) ? busy : busy_l, sz > 0);
            chk($sformatf("din_ready_d%0d", d), (d == 0) ? din_ready : din_ready_l,
                !(exv ? (sz > W) : (sz > 0)));
            chk($sformatf("word_done_d%0d", d), (d == 0) ? word_done : word_done_l,
                cons[d] && (consumed[d] % W == 0));
            if (!exv) chk($sformatf("x_zero_d%0d", d), (d == 0) ? x : x_l, 0);
        end
    endtask

    task automatic drain();
        int n = 0;
        step = 1'b1;
        din_valid = 1'b0;
        while ((qsize(0) > 0 || qsize(1) > 0) && n < 200) begin
            cyc();
            n++;
        end
        chk("drain_empty", qsize(0) + qsize(1), 0);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    logic [W-1:0]  tmp;
    logic [15:0]   stream;
    int            idx, nb, first, last, d1, d2, n;
    bit            acc_now;

    initial begin
        model_reset();
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", x, 0);
        chk("rst_x_valid", x_valid, 0);
        chk("rst_word_done", word_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_din_ready", din_ready, 1);
        chk("rst_din_ready_l", din_ready_l, 1);
        res = 1'b1;
        cyc();

        // Single word A5, MSB first, step held
        din = 8'hA5; din_valid = 1'b1; step = 1'b1;
        cyc();
        din_valid = 1'b0;
        chk("t1_acc_x_valid", x_valid, 0);
        chk("t1_acc_busy", busy, 1);
        chk("t1_acc_din_ready", din_ready, 0);
        tmp = 8'hA5;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk("t1_x", x, tmp[8-k]);
            chk("t1_x_valid", x_valid, 1);
            chk("t1_no_done", word_done, 0);
        end
        cyc();
        chk("t1_end_x_valid", x_valid, 0);
        chk("t1_end_done", word_done, 1);
        cyc();
        chk("t1_done_once", word_done, 0);

        // Back-to-back A5, 3C
        idx = 0; stream = '0; nb = 0; first = -1; last = -1; d1 = -1; d2 = -1;
        for (int c = 0; c < 24; c++) begin
            if (idx < 2) begin
                din = (idx == 0) ? 8'hA5 : 8'h3C;
                din_valid = 1'b1;
            end else begin
                din_valid = 1'b0;
            end
            acc_now = din_valid && din_ready;
            cyc();
            if (acc_now) idx++;
            if (x_valid) begin
                stream = {stream[14:0], x};
                nb++;
                if (first < 0) first = c;
                last = c;
            end
            if (word_done) begin
                if (d1 < 0) d1 = c;
                else d2 = c;
            end
        end
        din_valid = 1'b0;
        chk("t2_stream", stream, 16'hA53C);
        chk("t2_nbits", nb, 16);
        chk("t2_contiguous", last - first + 1, 16);
        chk("t2_done_gap", d2 - d1, 8);

        // F0 with a three-cycle stall after the second bit
        step = 1'b0; din = 8'hF0; din_valid = 1'b1;
        cyc();
        din_valid = 1'b0;
        cyc();
        step = 1'b1;
        cyc();
        cyc();
        chk("t3_before_stall", x, 1);
        step = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t3_stall_x", x, 1);
            chk("t3_stall_valid", x_valid, 1);
        end
        step = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            n++;
            if (word_done) break;
        end
        chk("t3_remaining_steps", n, 6);
        cyc();

        // din_valid held against a full buffer
        step = 1'b0; din = 8'h11; din_valid = 1'b1;
        cyc();
        din = 8'h22;
        chk("t4_ready_full", din_ready, 0);
        cyc();
        chk("t4_ready_after_take", din_ready, 1);
        chk("t4_first_loaded", x_valid, 1);
        cyc();
        chk("t4_second_held", din_ready, 0);
        drain();

        // Reset mid-word with a second word buffered
        step = 1'b1; din = 8'h5A; din_valid = 1'b1;
        cyc();
        din = 8'h77;
        cyc();
        cyc();
        din_valid = 1'b0;
        cyc();
        cyc();
        chk("t5_pre_busy", busy, 1);
        chk("t5_pre_ready", din_ready, 0);
        res = 1'b0;
        #1;
        model_reset();
        chk("t5_x", x, 0);
        chk("t5_x_valid", x_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_din_ready", din_ready, 1);
        chk("t5_x_valid_l", x_valid_l, 0);
        chk("t5_busy_l", busy_l, 0);
        @(posedge clk);
        #1;
        res = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cyc();
            chk("t5_no_bits", x_valid, 0);
            chk("t5_no_done", word_done, 0);
        end

        // 01 through both bit orders
        step = 1'b1; din = 8'h01; din_valid = 1'b1;
        cyc();
        din_valid = 1'b0;
        tmp = 8'h01;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk("t6_x_msb", x, tmp[8-k]);
            chk("t6_x_lsb", x_l, tmp[k-1]);
        end
        cyc();
        chk("t6_done_l", word_done_l, 1);
        cyc();

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            din       = W'($urandom);
            din_valid = ($urandom % 3) != 0;
            step      = ($urandom % 4) != 0;
            cyc();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
